migu_alu_exec_stage: RTL and testbench

- Two-stage valid/ready execute pipeline around the MigU integer ALU.
- S1 registers the issued ALU command and operands. The combinational ALU evaluates between S1 and S2. S2 registers the result and the condition flags (Z, N, C, V).
- Sits between the MigU issue/decode stage (upstream) and writeback (downstream).
- Sustains 1 op/cycle; fixed 2-cycle latency from accept to out_valid when there is no backpressure.

---
 rtl/migu_pkg.sv | 34 +++
 rtl/migu_alu.sv | 48 ++++
 rtl/migu_alu_flags.sv | 45 ++++
 rtl/migu_alu_exec_stage.sv | 108 ++++++++++
 tb/tb_migu_alu_exec_stage.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/migu_pkg.sv
// Shared MigU ALU definitions: command encodings, flag bit positions and command-class helpers.
package migu_pkg;

    localparam int MIGU_ALU_CMD_WIDTH   = 4;
    localparam int MIGU_ALU_NR_COMMANDS = 12;

    localparam logic [MIGU_ALU_CMD_WIDTH-1:0] CMD_PASS_A  = 4'd0;
    localparam logic [MIGU_ALU_CMD_WIDTH-1:0] CMD_INC     = 4'd1;
    localparam logic [MIGU_ALU_CMD_WIDTH-1:0] CMD_ADD     = 4'd2;
    localparam logic [MIGU_ALU_CMD_WIDTH-1:0] CMD_ADD_C   = 4'd3;
    localparam logic [MIGU_ALU_CMD_WIDTH-1:0] CMD_ADD_NB  = 4'd4;
    localparam logic [MIGU_ALU_CMD_WIDTH-1:0] CMD_SUB     = 4'd5;
    localparam logic [MIGU_ALU_CMD_WIDTH-1:0] CMD_DEC     = 4'd6;
    localparam logic [MIGU_ALU_CMD_WIDTH-1:0] CMD_PASS_AC = 4'd7;
    localparam logic [MIGU_ALU_CMD_WIDTH-1:0] CMD_AND     = 4'd8;
    localparam logic [MIGU_ALU_CMD_WIDTH-1:0] CMD_OR      = 4'd9;
    localparam logic [MIGU_ALU_CMD_WIDTH-1:0] CMD_XOR     = 4'd10;
    localparam logic [MIGU_ALU_CMD_WIDTH-1:0] CMD_NOT     = 4'd11;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Commands 0-7 all go through the adder; bit 3 selects the logic unit.
    function automatic logic cmd_is_arith(input logic [MIGU_ALU_CMD_WIDTH-1:0] cmd);
        return !cmd[3];
    endfunction

    function automatic logic cmd_is_legal(input logic [MIGU_ALU_CMD_WIDTH-1:0] cmd);
        return cmd < MIGU_ALU_CMD_WIDTH'(MIGU_ALU_NR_COMMANDS);
    endfunction

endpackage

// File: rtl/migu_alu.sv
// MigU integer ALU: one shared adder for commands 0-7, bitwise unit for 8-11, zero for reserved codes.
module migu_alu
    import migu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [MIGU_ALU_CMD_WIDTH-1:0] cmd,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    output logic [WIDTH-1:0]              result,
    output logic                          co
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // cmd[2:1] picks the adder's second operand, cmd[0] is the carry-in.
    always_comb begin
        b_eff = '0;
        case (cmd[2:1])
            2'd0: b_eff = '0;
            2'd1: b_eff = b;
            2'd2: b_eff = ~b;
            2'd3: b_eff = '1;
            default: b_eff = '0;
        endcase
    end

    assign sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cmd[0]};

    always_comb begin
        result = '0;
        co     = 1'b0;
        if (cmd_is_arith(cmd)) begin
            result = sum[WIDTH-1:0];
            co     = sum[WIDTH];
        end else begin
            case (cmd)
                CMD_AND: result = a & b;
                CMD_OR:  result = a | b;
                CMD_XOR: result = a ^ b;
                CMD_NOT: result = ~a;
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/migu_alu_flags.sv
// Condition flag and reserved-command decode for the MigU ALU result.
module migu_alu_flags
    import migu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [MIGU_ALU_CMD_WIDTH-1:0] cmd,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    input  logic [WIDTH-1:0]              result,
    input  logic                          co,
    output logic [3:0]                    flags,
    output logic                          illegal
);

    logic b_eff_msb;
    logic arith;
    logic unused_low_bits;

    assign unused_low_bits = ^{a[WIDTH-2:0], b[WIDTH-2:0]};
    assign arith           = cmd_is_arith(cmd);

    // Only the sign bit of the effective adder operand matters for overflow.
    always_comb begin
        b_eff_msb = 1'b0;
        case (cmd[2:1])
            2'd0: b_eff_msb = 1'b0;
            2'd1: b_eff_msb = b[WIDTH-1];
            2'd2: b_eff_msb = ~b[WIDTH-1];
            2'd3: b_eff_msb = 1'b1;
            default: b_eff_msb = 1'b0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_C] = arith && co;
        flags[FLAG_V] = arith && (a[WIDTH-1] == b_eff_msb) && (result[WIDTH-1] != a[WIDTH-1]);
    end

    assign illegal = !cmd_is_legal(cmd);

endmodule

// File: rtl/migu_alu_exec_stage.sv
// Two-stage valid/ready execute pipeline: S1 holds the issued op, S2 holds result, flags and tag.
module migu_alu_exec_stage
    import migu_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int TAG_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MIGU_ALU_CMD_WIDTH-1:0] in_cmd,
    input  logic [WIDTH-1:0]              in_a,
    input  logic [WIDTH-1:0]              in_b,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_result,
    output logic [3:0]                    out_flags,
    output logic                          out_illegal,
    output logic [TAG_WIDTH-1:0]          out_tag
);

    logic                          s1_valid;
    logic [MIGU_ALU_CMD_WIDTH-1:0] s1_cmd;
    logic [WIDTH-1:0]              s1_a;
    logic [WIDTH-1:0]              s1_b;
    logic [TAG_WIDTH-1:0]          s1_tag;

    logic                          s2_valid;
    logic [WIDTH-1:0]              s2_result;
    logic [3:0]                    s2_flags;
    logic                          s2_illegal;
    logic [TAG_WIDTH-1:0]          s2_tag;

    logic                          s2_load;
    logic [WIDTH-1:0]              alu_result;
    logic                          alu_co;
    logic [3:0]                    alu_flags;
    logic                          alu_illegal;

    migu_alu #(.WIDTH(WIDTH)) u_alu (
        .cmd    (s1_cmd),
        .a      (s1_a),
        .b      (s1_b),
        .result (alu_result),
        .co     (alu_co)
    );

    migu_alu_flags #(.WIDTH(WIDTH)) u_flags (
        .cmd     (s1_cmd),
        .a       (s1_a),
        .b       (s1_b),
        .result  (alu_result),
        .co      (alu_co),
        .flags   (alu_flags),
        .illegal (alu_illegal)
    );

    // S2 only reloads when empty or draining, which keeps out_* stable under backpressure.
    assign s2_load  = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_cmd     <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_tag     <= '0;
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_flags   <= '0;
            s2_illegal <= 1'b0;
            s2_tag     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_cmd <= in_cmd;
                    s1_a   <= in_a;
                    s1_b   <= in_b;
                    s1_tag <= in_tag;
                end
            end
            if (s2_load) begin
                s2_valid   <= 1'b1;
                s2_result  <= alu_result;
                s2_flags   <= alu_flags;
                s2_illegal <= alu_illegal;
                s2_tag     <= s1_tag;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_result  = s2_result;
    assign out_flags   = s2_flags;
    assign out_illegal = s2_illegal;
    assign out_tag     = s2_tag;

endmodule

// File: tb/tb_migu_alu_exec_stage.sv
// Bench for migu_alu_exec_stage at WIDTH=8: directed cases plus random traffic against a transaction-level model.
module tb_migu_alu_exec_stage;

    localparam int W  = 8;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [3:0]    in_cmd, out_flags;
    logic [W-1:0]  in_a, in_b, out_result;
    logic [TW-1:0] in_tag, out_tag;

    always #5 clk = ~clk;

    migu_alu_exec_stage #(.WIDTH(W), .TAG_WIDTH(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cmd      (in_cmd),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    typedef struct {
        logic [W-1:0]  res;
        logic [3:0]    fl;
        logic          ill;
        logic [TW-1:0] tag;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   delivered = 0;
    bit   last_acc = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: result from the command's arithmetic meaning, C/V from integer and signed sums.
    function automatic exp_t model(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [TW-1:0] tag);
        exp_t e;
        int ai, bi, r, bp, cin, full, sa, sb, s;
        bit c, v;
        ai = int'(a); bi = int'(b); cin = int'(cmd[0]);
        c = 0; v = 0; r = 0;
        case (cmd)
            0: r = ai;
            1: r = ai + 1;
            2: r = ai + bi;
            3: r = ai + bi + 1;
            4: r = ai + (255 - bi);
            5: r = ai - bi;
            6: r = ai - 1;
            7: r = ai;
            8: r = ai & bi;
            9: r = ai | bi;
            10: r = ai ^ bi;
            11: r = 255 - ai;
            default: r = 0;
        endcase
        if (cmd < 8) begin
            bp   = (cmd < 2) ? 0 : (cmd < 4) ? bi : (cmd < 6) ? 255 - bi : 255;
            full = ai + bp + cin;
            sa   = (ai > 127) ? ai - 256 : ai;
            sb   = (bp > 127) ? bp - 256 : bp;
            s    = sa + sb + cin;
            c    = full > 255;
            v    = (s > 127) || (s < -128);
        end
        e.res = W'(r & 255);
        e.fl  = {v, c, e.res[W-1], e.res == 0};
        e.ill = cmd > 11;
        e.tag = tag;
        e.acc = 0;
        return e;
    endfunction

    task automatic step();
        bit   exp_rdy, exp_vld, xin, xout;
        exp_t e;
        @(negedge clk);
        exp_rdy = (q.size() < 2) || out_ready;
        exp_vld = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, exp_vld);
        if (out_valid && q.size() > 0) begin
            chk("out_result", out_result, q[0].res);
            chk("out_flags", out_flags, q[0].fl);
            chk("out_illegal", out_illegal, q[0].ill);
            chk("out_tag", out_tag, q[0].tag);
        end
        xin  = in_valid && in_ready;
        xout = out_valid && out_ready;
        @(posedge clk);
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (xout && q.size() > 0) begin
                void'(q.pop_front());
                delivered++;
            end
            if (xin) begin
                e = model(in_cmd, in_a, in_b, in_tag);
                e.acc = cyc;
                q.push_back(e);
            end
        end
        last_acc = xin && rst_n && !flush;
        cyc++;
        #1;
    endtask

    task automatic op(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] tag);
        in_valid = 1'b1; in_cmd = cmd; in_a = a; in_b = b; in_tag = tag;
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] res, input logic [3:0] fl,
                              input logic ill, input logic [TW-1:0] t);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_result"}, out_result, res);
        chk({tag, "_flags"}, out_flags, fl);
        chk({tag, "_illegal"}, out_illegal, ill);
        chk({tag, "_tag"}, out_tag, t);
    endtask

    task automatic expect_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_result"}, out_result, 0);
        chk({tag, "_flags"}, out_flags, 0);
        chk({tag, "_illegal"}, out_illegal, 0);
        chk({tag, "_tag"}, out_tag, 0);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 3)];
        return W'($urandom);
    endfunction

    initial begin
        int n_acc, d0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_cmd = '0; in_a = '0; in_b = '0; in_tag = '0;
        step(); step();
        expect_zero("reset");
        rst_n = 1'b1;

        // ADD signed overflow
        op(4'd2, 8'h7F, 8'h01, 4'h1); step();
        in_valid = 1'b0; step();
        expect_out("add_ovf", 8'h80, 4'b1010, 1'b0, 4'h1);
        step();

        // SUB equal then DEC of 0x80, back to back
        op(4'd5, 8'h05, 8'h05, 4'h2); step();
        op(4'd6, 8'h80, 8'h00, 4'h3); step();
        expect_out("sub_eq", 8'h00, 4'b0101, 1'b0, 4'h2);
        in_valid = 1'b0; step();
        expect_out("dec_80", 8'h7F, 4'b1100, 1'b0, 4'h3);
        step(); step();

        // Backpressure: only two ops fit, head stays stable, then in-order drain
        out_ready = 1'b0; n_acc = 0; d0 = delivered;
        for (int i = 0; i < 6; i++) begin
            op(4'd2, W'(n_acc * 16), 8'h01, TW'(n_acc));
            step();
            if (last_acc) n_acc++;
        end
        chk("bp_accepts", n_acc, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_head_tag", out_tag, 4'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (n_acc < 4) op(4'd2, W'(n_acc * 16), 8'h01, TW'(n_acc));
            else in_valid = 1'b0;
            step();
            if (last_acc) n_acc++;
        end
        chk("bp_delivered", delivered - d0, 4);

        // Flush with two in flight and a simultaneous accept
        out_ready = 1'b0;
        op(4'd0, 8'h11, 8'h00, 4'h5); step();
        op(4'd1, 8'h22, 8'h00, 4'h6); step();
        op(4'd2, 8'h33, 8'h01, 4'h7); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_s1_empty", in_ready, 1'b1);
        out_ready = 1'b1;
        op(4'd3, 8'h10, 8'h20, 4'h8); step();
        in_valid = 1'b0; step();
        expect_out("post_flush", 8'h31, 4'b0000, 1'b0, 4'h8);
        step();

        // Reserved command and XOR
        op(4'd13, 8'hAA, 8'h55, 4'h9); step();
        in_valid = 1'b0; step();
        expect_out("illegal", 8'h00, 4'b0001, 1'b1, 4'h9);
        op(4'd10, 8'hF0, 8'hFF, 4'hA); step();
        in_valid = 1'b0; step();
        expect_out("xor", 8'h0F, 4'b0000, 1'b0, 4'hA);
        step();

        // Reset with a full pipe
        out_ready = 1'b0;
        op(4'd2, 8'h01, 8'h02, 4'hB); step();
        op(4'd2, 8'h03, 8'h04, 4'hC); step();
        rst_n = 1'b0; step();
        expect_zero("mid_reset");
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        chk("reset_in_ready", in_ready, 1'b1);
        step();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 31) == 0;
            in_cmd    = 4'($urandom_range(0, 15));
            in_a      = pick();
            in_b      = pick();
            in_tag    = TW'($urandom);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
